mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Consumer end of the execute-stage result path. It accepts one ALU result per cycle from execute, runs a load or store against data memory with a req/ready handshake, and presents a registered writeback record to the register file. While a memory access is outstanding, it stalls execute.

Parameters:
DATA_W, 16, width of ALU result, store data, memory data and writeback data
ADDR_W, 16, data-memory address width; the address is the low ADDR_W bits of ex_result
REG_AW, 3, destination register index width

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
ex_valid  in  1  execute offers an instruction this cycle
ex_result  in  DATA_W  ALU output; used as memory address for loads and stores
ex_store_data  in  DATA_W  store operand (register_content2 path)
ex_dest  in  REG_AW  destination register index
ex_mem_read  in  1  instruction is a load
ex_mem_write  in  1  instruction is a store
ex_reg_write  in  1  instruction writes a register
stall_out  out  1  execute must hold its outputs; combinational from state only
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  ADDR_W  request address, registered
dmem_wdata  out  DATA_W  store data, registered
dmem_ready  in  1  memory completes the request at this edge
dmem_rdata  in  DATA_W  load data; valid when dmem_ready = 1
wb_valid  out  1  one-cycle retire pulse
wb_we  out  1  register-file write enable; only meaningful with wb_valid
wb_dest  out  REG_AW  writeback register index
wb_data  out  DATA_W  writeback data

Behaviour:
- Reset: rst_n = 0 at a posedge puts state in IDLE and clears every registered output (dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_we, wb_dest, wb_data) to 0. stall_out is 0 in IDLE.
- Reset mid-WAIT: the access is abandoned, dmem_req drops at the reset edge, and no wb_valid is produced for that instruction.
- States: IDLE and WAIT. stall_out = (state == WAIT).
- Acceptance: ex_valid is accepted only in IDLE. In WAIT, ex_* inputs are ignored; upstream holds them while stall_out = 1.
- IDLE, ex_valid, no memory op:
  - next edge: wb_valid = 1, wb_data = ex_result, wb_dest = ex_dest, wb_we = ex_reg_write.
  - latency is 1 cycle; back-to-back ALU instructions retire every cycle.
- IDLE, ex_valid, with a memory op:
  - next edge: dmem_req = 1, dmem_addr = ex_result[ADDR_W-1:0], dmem_we = ex_mem_write, dmem_wdata = ex_store_data.
  - ex_dest and ex_reg_write are latched internally, state goes to WAIT, and wb_valid = 0.
- WAIT:
  - dmem_req, dmem_addr, dmem_we and dmem_wdata stay stable until dmem_ready is sampled 1.
  - On the dmem_ready edge, dmem_req goes to 0, state returns to IDLE and wb_valid = 1.
  - Load: wb_data = dmem_rdata, wb_we = latched reg_write.
  - Store: wb_we = 0, and wb_data = address.
  - Minimum load-to-writeback latency is 2 cycles (ready high on the first req cycle).
- dmem_ready while dmem_req = 0 is ignored.
- wb_valid is a one-cycle pulse. When no instruction retires, wb_valid = 0 and wb_we = 0; wb_dest and wb_data hold their last values.
- ex_mem_read and ex_mem_write both 1: treated as a store, and the register write is suppressed.
- The first instruction accepted after WAIT returns to IDLE is accepted on the edge following the retire edge. Execute sees stall_out fall in that cycle.

Optional Feature:
WB_FORWARD_EN
- Defined: adds outputs fwd_valid (1), fwd_dest (REG_AW) and fwd_data (DATA_W), all combinational.
  - fwd_valid = wb_valid & wb_we; fwd_dest = wb_dest; fwd_data = wb_data.
  - Execute uses these to bypass the register file.
  - In WAIT, fwd_valid = 0.
- Undefined: the ports are absent and there is no forwarding logic. Core behaviour is identical in both cases.

Test Plan:
1. rst_n = 0 for 2 cycles with garbage on ex_* -> all outputs 0, stall_out = 0; release, and the first ex_valid is accepted.
2. Three back-to-back ALU ops: result 0x0011 to r1, 0x0022 to r2, 0xFFFF to r7 -> wb_valid high for 3 consecutive cycles with those values, each one cycle after its input.
3. Load with result 0x0040, dest r3, memory ready after 3 req cycles with rdata 0xBEEF:
   - dmem_req held 3 cycles with addr 0x0040 and we = 0, stall_out high throughout.
   - then wb_valid = 1, wb_we = 1, wb_dest = 3, wb_data = 0xBEEF.
4. Store: addr 0x0010, data 0x1234, ready on the first cycle -> dmem_we = 1, dmem_wdata = 0x1234; one cycle later wb_valid = 1 with wb_we = 0; the next ALU op is accepted the cycle after.
5. rst_n = 0 while in WAIT with dmem_ready = 0 -> dmem_req = 0 and stall_out = 0 after the edge, and no wb_valid pulse follows.
6. mem_read = mem_write = 1 with reg_write = 1 -> a write request is issued and wb_we = 0 at retire. With WB_FORWARD_EN, an ALU op to r5 with 0x00A5 gives fwd_valid = 1, fwd_dest = 5, fwd_data = 0x00A5.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Execute / data-memory / writeback signal bundle for mem_wb_stage.
// Forwarding outputs exist only when WB_FORWARD_EN is defined.
interface mem_wb_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_AW = 3
);
  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_reg_write;
  logic              stall_out;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ready;
  logic [DATA_W-1:0] dmem_rdata;

  logic              wb_valid;
  logic              wb_we;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
`ifdef WB_FORWARD_EN
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_dest;
  logic [DATA_W-1:0] fwd_data;
`endif

  modport master (
    output ex_valid, ex_result, ex_store_data, ex_dest,
           ex_mem_read, ex_mem_write, ex_reg_write,
           dmem_ready, dmem_rdata,
    input  stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_we, wb_dest, wb_data
`ifdef WB_FORWARD_EN
   ,input  fwd_valid, fwd_dest, fwd_data
`endif
  );

  modport slave (
    input  ex_valid, ex_result, ex_store_data, ex_dest,
           ex_mem_read, ex_mem_write, ex_reg_write,
           dmem_ready, dmem_rdata,
    output stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_we, wb_dest, wb_data
`ifdef WB_FORWARD_EN
   ,output fwd_valid, fwd_dest, fwd_data
`endif
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: retires ALU results in one cycle, runs loads/stores
// over a req/ready handshake while stalling execute. Optional macro WB_FORWARD_EN.
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_AW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_wb_stage_if.slave   bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  state_t            r_state;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_wdata;
  logic              r_wb_valid;
  logic              r_wb_we;
  logic [REG_AW-1:0] r_wb_dest;
  logic [DATA_W-1:0] r_wb_data;
  logic [REG_AW-1:0] r_pend_dest;
  logic              r_pend_reg_write;
  logic              w_mem_op;

  assign w_mem_op = bus.ex_mem_read | bus.ex_mem_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_dmem_req       <= 1'b0;
      r_dmem_we        <= 1'b0;
      r_dmem_addr      <= '0;
      r_dmem_wdata     <= '0;
      r_wb_valid       <= 1'b0;
      r_wb_we          <= 1'b0;
      r_wb_dest        <= '0;
      r_wb_data        <= '0;
      r_pend_dest      <= '0;
      r_pend_reg_write <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.ex_valid) begin
            if (w_mem_op) begin
              r_dmem_req       <= 1'b1;
              r_dmem_we        <= bus.ex_mem_write;
              r_dmem_addr      <= bus.ex_result[ADDR_W-1:0];
              r_dmem_wdata     <= bus.ex_store_data;
              r_pend_dest      <= bus.ex_dest;
              // read+write together behaves as a store, so no register write
              r_pend_reg_write <= bus.ex_reg_write & ~bus.ex_mem_write;
              r_state          <= WAIT;
            end else begin
              r_wb_valid <= 1'b1;
              r_wb_we    <= bus.ex_reg_write;
              r_wb_dest  <= bus.ex_dest;
              r_wb_data  <= bus.ex_result;
            end
          end
        end
        WAIT: begin
          if (bus.dmem_ready) begin
            r_dmem_req <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_dest  <= r_pend_dest;
            r_state    <= IDLE;
            if (r_dmem_we) begin
              r_wb_we   <= 1'b0;
              r_wb_data <= DATA_W'(r_dmem_addr);
            end else begin
              r_wb_we   <= r_pend_reg_write;
              r_wb_data <= bus.dmem_rdata;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stall_out  = (r_state == WAIT);
  assign bus.dmem_req   = r_dmem_req;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wdata = r_dmem_wdata;
  assign bus.wb_valid   = r_wb_valid;
  assign bus.wb_we      = r_wb_we;
  assign bus.wb_dest    = r_wb_dest;
  assign bus.wb_data    = r_wb_data;

`ifdef WB_FORWARD_EN
  assign bus.fwd_valid = r_wb_valid & r_wb_we;
  assign bus.fwd_dest  = r_wb_dest;
  assign bus.fwd_data  = r_wb_data;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (ALU retire, load, store,
// reset during a pending access, read+write conflict, optional forwarding).
module tb_mem_wb_stage;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_wb_stage_if #(.DATA_W(16), .ADDR_W(16), .REG_AW(3)) bus ();

  mem_wb_stage #(.DATA_W(16), .ADDR_W(16), .REG_AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [15:0] res, input logic [15:0] sd,
                          input logic [2:0] dest, input logic rd, input logic wr, input logic rw);
    bus.ex_valid      = v;
    bus.ex_result     = res;
    bus.ex_store_data = sd;
    bus.ex_dest       = dest;
    bus.ex_mem_read   = rd;
    bus.ex_mem_write  = wr;
    bus.ex_reg_write  = rw;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_ex(1'b1, 16'hDEAD, 16'hBEEF, 3'd6, 1'b1, 1'b0, 1'b1);
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 16'hCAFE;
    tick();
    tick();
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", bus.stall_out); end
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.dmem_req); end
    checks++; if ({bus.dmem_we, bus.dmem_addr, bus.dmem_wdata} !== 33'd0) begin errors++; $display("FAIL rst_dmem: we=%b addr=%h wdata=%h want 0", bus.dmem_we, bus.dmem_addr, bus.dmem_wdata); end
    checks++; if ({bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data} !== 21'd0) begin errors++; $display("FAIL rst_wb: v=%b we=%b dest=%0d data=%h want 0", bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data); end
    bus.dmem_ready = 1'b0;
    rst_n = 1'b1;
    drive_ex(1'b1, 16'h5A5A, 16'h0000, 3'd4, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if ({bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data} !== {1'b1, 1'b1, 3'd4, 16'h5A5A}) begin errors++; $display("FAIL rst_first_accept: v=%b we=%b dest=%0d data=%h want 1 1 4 5a5a", bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data); end
    drive_ex(1'b0, 16'h1111, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if ({bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data} !== {1'b0, 1'b0, 3'd4, 16'h5A5A}) begin errors++; $display("FAIL idle_hold: v=%b we=%b dest=%0d data=%h want 0 0 4 5a5a", bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] res [3];
    logic [2:0]  dst [3];
    res[0] = 16'h0011; dst[0] = 3'd1;
    res[1] = 16'h0022; dst[1] = 3'd2;
    res[2] = 16'hFFFF; dst[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b1, res[i], 16'h0000, dst[i], 1'b0, 1'b0, 1'b1);
      tick();
      checks++; if ({bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data, bus.stall_out} !== {1'b1, 1'b1, dst[i], res[i], 1'b0}) begin errors++; $display("FAIL b2b_%0d: v=%b we=%b dest=%0d data=%h stall=%b want 1 1 %0d %h 0", i, bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data, bus.stall_out, dst[i], res[i]); end
    end
    drive_ex(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: wb_valid got %b want 0", bus.wb_valid); end
  endtask

  task automatic test_load();
    bus.dmem_ready = 1'b1;
    tick();
    checks++; if ({bus.dmem_req, bus.wb_valid, bus.stall_out} !== 3'b000) begin errors++; $display("FAIL stray_ready: req=%b v=%b stall=%b want 000", bus.dmem_req, bus.wb_valid, bus.stall_out); end
    bus.dmem_ready = 1'b0;
    drive_ex(1'b1, 16'h0040, 16'h9999, 3'd3, 1'b1, 1'b0, 1'b1);
    tick();
    drive_ex(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++; if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.stall_out, bus.wb_valid} !== {1'b1, 1'b0, 16'h0040, 1'b1, 1'b0}) begin errors++; $display("FAIL load_req_%0d: req=%b we=%b addr=%h stall=%b v=%b want 1 0 0040 1 0", c, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.stall_out, bus.wb_valid); end
      if (c == 2) begin
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 16'hBEEF;
      end
      tick();
    end
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 16'h0000;
    checks++; if ({bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data} !== {1'b1, 1'b1, 3'd3, 16'hBEEF}) begin errors++; $display("FAIL load_wb: v=%b we=%b dest=%0d data=%h want 1 1 3 beef", bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data); end
    checks++; if ({bus.dmem_req, bus.stall_out} !== 2'b00) begin errors++; $display("FAIL load_done: req=%b stall=%b want 00", bus.dmem_req, bus.stall_out); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL load_pulse: wb_valid got %b want 0", bus.wb_valid); end
  endtask

  task automatic test_store();
    drive_ex(1'b1, 16'h0010, 16'h1234, 3'd6, 1'b0, 1'b1, 1'b0);
    tick();
    checks++; if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.stall_out} !== {1'b1, 1'b1, 16'h0010, 16'h1234, 1'b1}) begin errors++; $display("FAIL store_req: req=%b we=%b addr=%h wdata=%h stall=%b want 1 1 0010 1234 1", bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.stall_out); end
    // next instruction is held by upstream while stalled
    drive_ex(1'b1, 16'h0077, 16'h0000, 3'd2, 1'b0, 1'b0, 1'b1);
    bus.dmem_ready = 1'b1;
    tick();
    bus.dmem_ready = 1'b0;
    checks++; if ({bus.wb_valid, bus.wb_we, bus.wb_data, bus.stall_out, bus.dmem_req} !== {1'b1, 1'b0, 16'h0010, 1'b0, 1'b0}) begin errors++; $display("FAIL store_wb: v=%b we=%b data=%h stall=%b req=%b want 1 0 0010 0 0", bus.wb_valid, bus.wb_we, bus.wb_data, bus.stall_out, bus.dmem_req); end
    tick();
    drive_ex(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if ({bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data} !== {1'b1, 1'b1, 3'd2, 16'h0077}) begin errors++; $display("FAIL store_next: v=%b we=%b dest=%0d data=%h want 1 1 2 0077", bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    drive_ex(1'b1, 16'h0080, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b1);
    tick();
    drive_ex(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if ({bus.dmem_req, bus.stall_out} !== 2'b11) begin errors++; $display("FAIL rw_pre: req=%b stall=%b want 11", bus.dmem_req, bus.stall_out); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if ({bus.dmem_req, bus.stall_out, bus.wb_valid} !== 3'b000) begin errors++; $display("FAIL rw_reset: req=%b stall=%b v=%b want 000", bus.dmem_req, bus.stall_out, bus.wb_valid); end
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 16'h4321;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if ({bus.wb_valid, bus.dmem_req} !== 2'b00) begin errors++; $display("FAIL rw_no_retire_%0d: v=%b req=%b want 00", c, bus.wb_valid, bus.dmem_req); end
    end
    bus.dmem_ready = 1'b0;
  endtask

  task automatic test_rw_conflict();
    drive_ex(1'b1, 16'h0020, 16'h5555, 3'd4, 1'b1, 1'b1, 1'b1);
    tick();
    drive_ex(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata} !== {1'b1, 1'b1, 16'h0020, 16'h5555}) begin errors++; $display("FAIL conflict_req: req=%b we=%b addr=%h wdata=%h want 1 1 0020 5555", bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata); end
`ifdef WB_FORWARD_EN
    checks++; if (bus.fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_wait: fwd_valid got %b want 0", bus.fwd_valid); end
`endif
    bus.dmem_ready = 1'b1;
    tick();
    bus.dmem_ready = 1'b0;
    checks++; if ({bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data} !== {1'b1, 1'b0, 3'd4, 16'h0020}) begin errors++; $display("FAIL conflict_wb: v=%b we=%b dest=%0d data=%h want 1 0 4 0020", bus.wb_valid, bus.wb_we, bus.wb_dest, bus.wb_data); end
`ifdef WB_FORWARD_EN
    checks++; if (bus.fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_store: fwd_valid got %b want 0", bus.fwd_valid); end
`endif
  endtask

  task automatic test_forward();
    drive_ex(1'b1, 16'h00A5, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b1);
    tick();
    drive_ex(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if ({bus.wb_valid, bus.wb_dest, bus.wb_data} !== {1'b1, 3'd5, 16'h00A5}) begin errors++; $display("FAIL alu_r5: v=%b dest=%0d data=%h want 1 5 00a5", bus.wb_valid, bus.wb_dest, bus.wb_data); end
`ifdef WB_FORWARD_EN
    checks++; if ({bus.fwd_valid, bus.fwd_dest, bus.fwd_data} !== {1'b1, 3'd5, 16'h00A5}) begin errors++; $display("FAIL fwd_alu: v=%b dest=%0d data=%h want 1 5 00a5", bus.fwd_valid, bus.fwd_dest, bus.fwd_data); end
`endif
    tick();
`ifdef WB_FORWARD_EN
    checks++; if (bus.fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_idle: fwd_valid got %b want 0", bus.fwd_valid); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = '0;
    drive_ex(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_back_to_back();
    test_load();
    test_store();
    test_reset_in_wait();
    test_rw_conflict();
    test_forward();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
